mcp3_arb004: RTL and testbench
==============================

# mcp3_arb004

Four-requester round-robin arbiter for the MCP3 AFU engine sequencers. It grants one requester at a time and holds the grant until that requester releases it. It exports a registered one-hot grant and a one-hot priority pointer. Both feed the downstream 4-bit one-hot checker, which flags any pointer corruption as a one-hot error.

## Interface
Parameters:
- HOLD_LIMIT, 255, maximum cycles a grant may be held (1–65535); used only when the timeout feature is compiled in.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- req  in  4  level request per requester; bit i = requester i.
- done  in  4  one-cycle release pulse per requester; only the bit of the current winner is honoured.
- grant  out  4  registered grant; either exactly one bit set or all zero.
- grant_valid  out  1  OR of grant, registered alongside it.
- priority_ptr  out  4  registered one-hot pointer to the highest-priority requester for the next arbitration; always exactly one bit set.
- timeout_err  out  1  sticky hold-timeout flag; tied 0 when the feature is compiled out.

## Operation
- Two states, IDLE and BUSY, plus a 4-bit winner register, which equals grant.
- IDLE:
  - If req is zero, remain in IDLE with grant = 0.
  - Otherwise, pick the first set req bit, searching upward from the priority_ptr bit and wrapping 3→0.
  - Load grant with that one-hot winner, go to BUSY, and rotate priority_ptr to the bit after the winner (winner 3 → 4'b0001).
- BUSY:
  - Release when done[w] = 1 or req[w] = 0, where w is the winner.
  - On release, grant → 0 and go to IDLE. priority_ptr is unchanged.
  - Done bits for non-winners are ignored. Req changes on non-winners are ignored.
- After every release there is one idle cycle before the next grant. Back-to-back grants are not allowed.
- done and req deasserting together count as a single release.
- priority_ptr changes only at grant time. It is never zero and never has more than one bit set.

## Timing
- Reset values: grant = 4'b0000, grant_valid = 0, priority_ptr = 4'b0001, timeout_err = 0, state = IDLE, hold counter = 0.
- Reset asserted mid-grant: all of the above take effect at the next edge, overriding any release or grant in that cycle.
- Grant latency: req sampled in IDLE at edge N → grant and grant_valid high from edge N+1.
- Release latency: release condition sampled at edge M → grant = 0 after edge M. The earliest next grant is after edge M+1.
- Minimum grant duration is 1 cycle, for example when done arrives on the first BUSY cycle.
- Under full load, each requester waits at most 3 complete grant tenures plus 3 idle cycles.

## Configuration
- MCP3_ARB004_TIMEOUT_EN defined:
  - A 16-bit hold counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches HOLD_LIMIT with no release, force a release: grant → 0, go to IDLE, and set timeout_err = 1.
  - timeout_err stays set until reset.
  - A normal release on the same cycle as the limit takes precedence, and timeout_err is not set.
- MCP3_ARB004_TIMEOUT_EN undefined:
  - No counter is built. A grant is held indefinitely until release.
  - timeout_err is a constant 0.

## Test plan
- Reset: assert reset for 2 cycles with req = 4'b1111 → grant = 0, grant_valid = 0, priority_ptr = 4'b0001, timeout_err = 0 throughout.
- Full rotation: req = 4'b1111 held, done[w] pulsed 2 cycles after each grant → grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001. priority_ptr steps 0010, 0100, 1000, 0001.
- Wrap search: grant bit 1, then release (priority_ptr = 0100), then req = 4'b0011 → next grant = 0001 and priority_ptr = 0010.
- Release rules: while grant = 0100, pulse done = 4'b0011 → grant holds. Then drop req[2] → grant = 0 on the next cycle and state = IDLE.
- Timeout with HOLD_LIMIT = 4 and the macro defined: req = 4'b0001 held, no done → grant drops after 4 BUSY cycles and timeout_err = 1 and stays set. With the macro undefined, the same stimulus holds grant = 0001 for 100+ cycles and timeout_err = 0.
- Reset mid-grant: grant = 1000 and priority_ptr = 0001, then pulse reset → next cycle grant = 0, priority_ptr = 0001. The first grant after reset, with req = 4'b1010, is 0010.

Source files
------------

// File: rtl/mcp3_arb004.sv
// ---------------------------------------------------------------------------
// mcp3_arb004 -- four-requester round-robin arbiter for the MCP3 AFU engine
// sequencers.
//
// One requester is granted at a time. The grant is held until the winner
// releases it by pulsing its done bit or by dropping its req bit. Every
// release is followed by one idle cycle before the next grant. The search
// for a winner starts at the priority pointer and wraps from 3 to 0. The
// pointer then rotates to the bit after the winner.
//
// Optional feature (compile-time macro MCP3_ARB004_TIMEOUT_EN):
//   A 16-bit hold counter forces a release after HOLD_LIMIT busy cycles
//   and sets the sticky timeout_err flag. Without the macro, no counter is
//   built and timeout_err is tied to 0.
//
// Parameters:
//   HOLD_LIMIT    maximum busy cycles per grant (1..65535), timeout build only
//
// Ports:
//   clock         rising-edge clock for all state
//   reset         synchronous, active-high reset
//   req[3:0]      level request per requester
//   done[3:0]     one-cycle release pulse; only the winner's bit is honoured
//   grant[3:0]    registered one-hot grant, or all zero
//   grant_valid   registered OR of grant
//   priority_ptr  registered one-hot pointer to the next highest-priority bit
//   timeout_err   sticky hold-timeout flag
//   state_dbg     FSM state for observation (0 = IDLE, 1 = BUSY)
//
// Handshake: req is a level. A requester keeps req high until it sees its
// grant bit. It holds req for as long as it wants the grant. It gives the
// grant back by pulsing done for one cycle or by dropping req; both together
// count as one release.
// ---------------------------------------------------------------------------
module mcp3_arb004 #(
  parameter int unsigned HOLD_LIMIT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic [3:0] priority_ptr,
  output logic       timeout_err,
  output logic       state_dbg
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Reject an out-of-range hold limit at elaboration time.
  if (HOLD_LIMIT < 1 || HOLD_LIMIT > 65535) begin : g_bad_hold_limit
    $error("mcp3_arb004: HOLD_LIMIT out of range 1..65535");
  end

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic       grant_valid_q, grant_valid_d;
  logic [3:0] ptr_q, ptr_d;

  logic [3:0] pick;        // one-hot winner of the rotating search
  logic       norm_release; // winner's done pulse or req drop
  logic       hold_expire; // hold limit reached in BUSY
  logic       release_w;

  // Rotating priority search: start at the pointer bit, walk upward, wrap.
  always_comb begin
    logic [1:0] ptr_idx;
    logic [1:0] idx;
    logic       found;
    pick    = 4'b0000;
    ptr_idx = 2'd0;
    idx     = 2'd0;
    found   = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (ptr_q[p]) ptr_idx = 2'(p);
    end
    for (int k = 0; k < 4; k++) begin
      idx = ptr_idx + 2'(k);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // grant_q holds the winner while BUSY, so masking with it selects only
  // the winner's done and req bits.
  assign norm_release = (|(grant_q & done)) | ~(|(grant_q & req));

`ifdef MCP3_ARB004_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_LIMIT - 1);

  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        timeout_err_q, timeout_err_d;

  // The counter is 0 on the first BUSY cycle. A value of HOLD_LIMIT-1
  // therefore marks the HOLD_LIMIT-th busy cycle.
  assign hold_expire = (state_q == BUSY) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    hold_cnt_d    = 16'd0;
    timeout_err_d = timeout_err_q;
    if (state_q == BUSY) begin
      hold_cnt_d = hold_cnt_q + 16'd1;
      // A normal release on the limit cycle wins and leaves the flag clear.
      if (hold_expire && !norm_release) timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt_q    <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      hold_cnt_q    <= hold_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign hold_expire = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign release_w = norm_release | hold_expire;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= 4'b0000;
      grant_valid_q <= 1'b0;
      ptr_q         <= 4'b0001;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = BUSY;
      BUSY:    if (release_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        if (|req) begin
          grant_d = pick;
          // Rotate to the bit after the winner; winner 3 wraps to bit 0.
          ptr_d   = {pick[2:0], pick[3]};
        end
      end
      BUSY: begin
        if (release_w) grant_d = 4'b0000;
      end
      default: grant_d = 4'b0000;
    endcase
    grant_valid_d = |grant_d;
  end

  assign grant        = grant_q;
  assign grant_valid  = grant_valid_q;
  assign priority_ptr = ptr_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_mcp3_arb004.sv
module tb_mcp3_arb004;

  // ---------------- clock / reset ----------------
  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [3:0] priority_ptr;
  logic       timeout_err;
  logic       state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef MCP3_ARB004_TIMEOUT_EN
  mcp3_arb004 #(.HOLD_LIMIT(4)) dut (
`else
  mcp3_arb004 dut (
`endif
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .done         (done),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .priority_ptr (priority_ptr),
    .timeout_err  (timeout_err),
    .state_dbg    (state_dbg)
  );

  // ---------------- driver / check tasks ----------------
  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] p);
    chk({tag, ".grant"}, grant, g);
    chk({tag, ".gvalid"}, {3'b000, grant_valid}, {3'b000, |g});
    chk({tag, ".ptr"}, priority_ptr, p);
  endtask

  // Observe a fresh grant, hold one cycle, pulse the winner's done,
  // and see the idle cycle that follows.
  task automatic rot(input string tag, input logic [3:0] g, input logic [3:0] p);
    chk_out({tag, ".new"}, g, p);
    chk({tag, ".busy"}, {3'b000, state_dbg}, 4'b0001);
    tick();
    chk_out({tag, ".hold"}, g, p);
    done = g;
    tick();
    done = 4'b0000;
    chk_out({tag, ".rel"}, 4'b0000, p);
    chk({tag, ".idle"}, {3'b000, state_dbg}, 4'b0000);
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    req   = 4'b1111;
    done  = 4'b0000;

    // Reset held for two cycles with all requests high.
    tick();
    chk_out("rst0", 4'b0000, 4'b0001);
    chk("rst0.terr", {3'b000, timeout_err}, 4'b0000);
    tick();
    chk_out("rst1", 4'b0000, 4'b0001);
    chk("rst1.terr", {3'b000, timeout_err}, 4'b0000);
    reset = 1'b0;
    tick();

    // Full rotation under full load.
    rot("rot0", 4'b0001, 4'b0010);
    rot("rot1", 4'b0010, 4'b0100);
    rot("rot2", 4'b0100, 4'b1000);
    rot("rot3", 4'b1000, 4'b0001);
    chk_out("rot4", 4'b0001, 4'b0010);

    // Wrap search: grant bit 1, release, then only bits 0/1 request.
    done = 4'b0001;
    tick();
    done = 4'b0000;
    chk_out("wrap.rel0", 4'b0000, 4'b0010);
    tick();
    chk_out("wrap.g1", 4'b0010, 4'b0100);
    done = 4'b0010;
    tick();
    done = 4'b0000;
    req  = 4'b0011;
    chk_out("wrap.rel1", 4'b0000, 4'b0100);
    tick();
    chk_out("wrap.g0", 4'b0001, 4'b0010);

    // Release rules: dropping req[0] releases; then grant bit 2.
    req = 4'b0100;
    tick();
    chk_out("rr.rel", 4'b0000, 4'b0010);
    tick();
    chk_out("rr.g2", 4'b0100, 4'b1000);
    done = 4'b0011;       // non-winner done bits: ignored
    req  = 4'b1111;       // non-winner req changes: ignored
    tick();
    done = 4'b0000;
    chk_out("rr.ignore", 4'b0100, 4'b1000);
    req = 4'b1011;        // winner drops its request
    tick();
    chk_out("rr.drop", 4'b0000, 4'b1000);
    chk("rr.idle", {3'b000, state_dbg}, 4'b0000);
    tick();
    chk_out("rr.g3", 4'b1000, 4'b0001);

    // Reset in the middle of a grant.
    reset = 1'b1;
    req   = 4'b1010;
    tick();
    reset = 1'b0;
    chk_out("mid.rst", 4'b0000, 4'b0001);
    chk("mid.idle", {3'b000, state_dbg}, 4'b0000);
    tick();
    chk_out("mid.first", 4'b0010, 4'b0100);

    // Done and req drop together on the first busy cycle: one release.
    done = 4'b0010;
    req  = 4'b1000;
    tick();
    done = 4'b0000;
    chk_out("both.rel", 4'b0000, 4'b0100);
    tick();
    chk_out("both.g3", 4'b1000, 4'b0001);

    // Hold test with a single requester and no done.
    req = 4'b0001;
    tick();
    chk_out("hold.rel", 4'b0000, 4'b0001);
    tick();
    chk_out("hold.g0", 4'b0001, 4'b0010);
`ifdef MCP3_ARB004_TIMEOUT_EN
    // Four busy cycles in all, then a forced release.
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("to.hold", grant, 4'b0001);
      chk("to.terr0", {3'b000, timeout_err}, 4'b0000);
    end
    tick();
    chk_out("to.drop", 4'b0000, 4'b0010);
    chk("to.terr1", {3'b000, timeout_err}, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("to.sticky", {3'b000, timeout_err}, 4'b0001);
    end
`else
    for (int i = 0; i < 120; i++) begin
      tick();
      chk("nto.hold", grant, 4'b0001);
      chk("nto.terr", {3'b000, timeout_err}, 4'b0000);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
